imem_ctrl: RTL
==============

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, instruction memory address width (32 words).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ld_valid  in  1  loader word available.
REQ-005 ld_data  in  32  loader instruction word.
REQ-006 ld_last  in  1  qualifies final loader word.
REQ-007 ld_ready  out  1  loader word accepted this cycle.
REQ-008 reload  in  1  single-cycle pulse, return to IDLE for a new image.
REQ-009 f_req  in  1  fetch read request.
REQ-010 f_addr  in  ADDR_W  fetch word address.
REQ-011 f_gnt  out  1  fetch request issued to memory this cycle.
REQ-012 f_valid  out  1  fetch data valid.
REQ-013 f_data  out  32  fetch data.
REQ-014 m_address  out  ADDR_W  memory address.
REQ-015 m_data_in  out  32  memory write data.
REQ-016 m_rw  out  1  memory mode, 1 = read, 0 = write.
REQ-017 m_data_out  in  32  memory registered read data, one cycle after a read.
REQ-018 boot_done  out  1  high in RUN.
REQ-019 ld_count  out  ADDR_W+1  words written since last IDLE.

Function
REQ-020 FSM states IDLE, LOAD, RUN, encoded as 2 bits.
REQ-021 IDLE: ld_ready=0, f_gnt=0; ld_valid=1 -> LOAD next cycle, pointer=0.
REQ-022 LOAD: ld_ready=ld_valid; on accept m_rw=0, m_address=pointer, m_data_in=ld_data, pointer and ld_count +1.
REQ-023 LOAD -> RUN after the accept carrying ld_last=1, or after the accept at pointer=2^ADDR_W-1 (ld_count=32), whichever first; no wrap-around write.
REQ-024 LOAD: f_gnt=0 regardless of f_req; f_valid=0.
REQ-025 RUN: f_gnt=f_req when no loader write this cycle; on grant m_rw=1, m_address=f_addr.
REQ-026 f_valid SHALL assert exactly one cycle after f_gnt; f_data SHALL equal m_data_out combinationally.
REQ-027 Back-to-back grants SHALL give one f_valid per cycle, in order, throughput 1 word/cycle.
REQ-028 Idle cycles (no write, no grant): m_rw=1, m_address=0, m_data_in=0.
REQ-029 reload=1 in any state -> IDLE next cycle, ld_count=0, f_valid cleared next cycle; reload wins over all requests.
REQ-030 reload and ld_valid both high: no write, ld_ready=0.

Reset
REQ-031 reset low: state IDLE, pointer=0, ld_count=0, f_valid=0, boot_done=0, immediately and asynchronously.
REQ-032 Outputs during reset: ld_ready=0, f_gnt=0, m_rw=1, m_address=0, m_data_in=0.
REQ-033 Reset deasserted mid-load SHALL require a full reload; no partial state is kept.

Configuration
REQ-034 Macro IMEM_CTRL_WRLOCK_EN.
REQ-035 Defined: in RUN, ld_ready=0; writes only through reload -> LOAD.
REQ-036 Undefined: in RUN, ld_valid writes at pointer (saturating at 2^ADDR_W-1, ld_count saturates at 32) with priority over fetch; f_gnt=0 that cycle.

Structure
REQ-037 Shared package holds state typedef (IDLE=0, LOAD=1, RUN=2), RW_READ=1, RW_WRITE=0, ADDR_W default.
REQ-038 Single module; no sub-module.

Verification
REQ-039 Reset low mid-LOAD after 3 words -> state IDLE, ld_count=0, m_rw=1 same cycle.
REQ-040 Load 4 words 0x00000013.., ld_last on 4th -> ld_count=4, boot_done=1 next cycle; fetch addr 2 -> f_valid next cycle, f_data = 3rd word.
REQ-041 Stream 40 words without ld_last -> 32 accepted, RUN entered, ld_ready=0 from word 33 (WRLOCK defined).
REQ-042 f_req held 5 cycles, addrs 0..4 -> 5 consecutive f_valid with matching data, no bubbles.
REQ-043 WRLOCK undefined: ld_valid and f_req same RUN cycle -> write done, f_gnt=0, grant next cycle.
REQ-044 reload during fetch stream -> f_gnt=0 next cycle, f_valid=0 after, state IDLE.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot/fetch controller.
package imem_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/imem_ctrl_if.sv
// Single-port instruction memory bus: controller is master, RAM is slave.
interface imem_ctrl_if #(
  parameter int ADDR_W = imem_ctrl_pkg::ADDR_W_DEF
);

  logic [ADDR_W-1:0] m_address;
  logic [31:0]       m_data_in;
  logic              m_rw;
  logic [31:0]       m_data_out;

  modport master (
    output m_address,
    output m_data_in,
    output m_rw,
    input  m_data_out
  );

  modport slave (
    input  m_address,
    input  m_data_in,
    input  m_rw,
    output m_data_out
  );

endinterface

// File: rtl/imem_ctrl.sv
// Boot loader / fetch arbiter for a single-port instruction RAM.
// Define IMEM_CTRL_WRLOCK_EN to block loader writes once the image is running.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [31:0]       f_data,
  imem_ctrl_if.master       mem,
  output logic              boot_done,
  output logic [ADDR_W:0]   ld_count
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              wr_en;
  logic              gnt;
  logic              vld_p1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    gnt       = 1'b0;
    if (reload) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_valid) begin
            state_nxt = LOAD;
            ptr_nxt   = '0;
            cnt_nxt   = '0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            wr_en   = 1'b1;
            ptr_nxt = (ptr == PTR_MAX) ? ptr : ptr + 1'b1;
            cnt_nxt = cnt + 1'b1;
            // The last RAM slot ends the load even without ld_last: no wrap.
            if (ld_last || ptr == PTR_MAX) state_nxt = RUN;
          end
        end
        RUN: begin
`ifndef IMEM_CTRL_WRLOCK_EN
          if (ld_valid) begin
            wr_en   = 1'b1;
            ptr_nxt = (ptr == PTR_MAX) ? ptr : ptr + 1'b1;
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
`endif
          gnt = f_req & ~wr_en;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign ld_ready  = wr_en;
  assign f_gnt     = gnt;
  assign boot_done = (state == RUN);
  assign ld_count  = cnt;
  assign f_valid   = vld_p1;
  assign f_data    = mem.m_data_out;

  always_comb begin
    mem.m_rw      = RW_READ;
    mem.m_address = '0;
    mem.m_data_in = '0;
    if (wr_en) begin
      mem.m_rw      = RW_WRITE;
      mem.m_address = ptr;
      mem.m_data_in = ld_data;
    end else if (gnt) begin
      mem.m_address = f_addr;
    end
  end

  // Stage p0 -> p1: grant issued now, RAM data returns next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= gnt;
    end
  end

endmodule
